// File: rtl/accum_access_arbiter.sv
// Arbitrates the single accum_array port between requester A (read/write), requester B
// (read-only) and an internal clear engine; registers the port and routes read data back.
module accum_access_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_kick,
    output logic                  clr_busy,
    input  logic                  a_req,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [63:0]           a_din,
    output logic                  a_rvalid,
    output logic [63:0]           a_q,
    input  logic                  b_req,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_rvalid,
    output logic [63:0]           b_q,
    output logic [31:0]           mem_addr,
    output logic [63:0]           mem_din,
    output logic                  mem_we,
    input  logic [63:0]           mem_q
);

    // One past the last index; the clear engine stops when its counter reaches this.
    localparam logic [ADDR_WIDTH:0] ClrEnd = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_idx_q, clr_idx_d;
    logic                  last_grant_b_q, last_grant_b_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [63:0]           mem_din_q, mem_din_d;
    logic                  mem_we_q, mem_we_d;
    logic [RD_LAT:0]       tag_v_q, tag_o_q;
    logic                  tag_in_v, tag_in_o;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [63:0]           a_rdata_q, b_rdata_q;
    logic                  arb_ok, a_win, b_win, none_req, a_acc, b_acc;
    logic                  ret_a, ret_b;

    // Round robin: on contention the requester that did not win last time goes first.
    always_comb begin
        arb_ok   = (state_q == StIdle) && !clr_kick;
        a_win    = a_req && (!b_req || last_grant_b_q);
        b_win    = b_req && !a_win;
        none_req = !a_req && !b_req;
        a_ready  = arb_ok && (a_win || (none_req && last_grant_b_q));
        b_ready  = arb_ok && (b_win || (none_req && !last_grant_b_q));
        a_acc    = a_req && a_ready;
        b_acc    = b_req && b_ready;
    end

    always_comb begin
        state_d        = state_q;
        clr_idx_d      = clr_idx_q;
        last_grant_b_d = last_grant_b_q;
        mem_addr_d     = mem_addr_q;
        mem_din_d      = '0;
        mem_we_d       = 1'b0;
        tag_in_v       = 1'b0;
        tag_in_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_kick) begin
                    state_d    = StClear;
                    mem_addr_d = '0;
                    mem_we_d   = 1'b1;
                    clr_idx_d  = (ADDR_WIDTH+1)'(1);
                end else if (a_acc) begin
                    last_grant_b_d = 1'b0;
                    mem_addr_d     = 32'(a_addr);
                    mem_we_d       = a_we;
                    mem_din_d      = a_we ? a_din : 64'd0;
                    tag_in_v       = !a_we;
                end else if (b_acc) begin
                    last_grant_b_d = 1'b1;
                    mem_addr_d     = 32'(b_addr);
                    tag_in_v       = 1'b1;
                    tag_in_o       = 1'b1;
                end
            end
            StClear: begin
                if (clr_idx_q == ClrEnd) begin
                    state_d = StIdle;
                end else begin
                    mem_addr_d = 32'(clr_idx_q[ADDR_WIDTH-1:0]);
                    mem_we_d   = 1'b1;
                    clr_idx_d  = clr_idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Oldest tag lines up with mem_q; its owner selects which return port fires.
    assign ret_a = tag_v_q[RD_LAT] && !tag_o_q[RD_LAT];
    assign ret_b = tag_v_q[RD_LAT] && tag_o_q[RD_LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            clr_idx_q      <= '0;
            last_grant_b_q <= 1'b1;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            mem_we_q       <= 1'b0;
            tag_v_q        <= '0;
            tag_o_q        <= '0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            last_grant_b_q <= last_grant_b_d;
            mem_addr_q     <= mem_addr_d;
            mem_din_q      <= mem_din_d;
            mem_we_q       <= mem_we_d;
            tag_v_q        <= {tag_v_q[RD_LAT-1:0], tag_in_v};
            tag_o_q        <= {tag_o_q[RD_LAT-1:0], tag_in_o};
            a_rvalid_q     <= ret_a;
            b_rvalid_q     <= ret_b;
            if (ret_a) a_rdata_q <= mem_q;
            if (ret_b) b_rdata_q <= mem_q;
        end
    end

    assign clr_busy = (state_q == StClear);
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_q      = a_rdata_q;
    assign b_q      = b_rdata_q;

endmodule
